// File: rtl/axi_burst_read_master_if.sv
// axi_burst_read_master_if: AXI4 read address and read data channels between a read master and slave.
interface axi_burst_read_master_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 8
);
    logic [ADDRESS_WIDTH-1:0] araddr;
    logic [7:0]               arlen;
    logic [2:0]               arsize;
    logic [1:0]               arburst;
    logic                     arvalid;
    logic                     arready;
    logic [DATA_WIDTH-1:0]    rdata;
    logic [1:0]               rresp;
    logic                     rlast;
    logic                     rvalid;
    logic                     rready;

    modport master (
        output araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_burst_read_master.sv
// axi_burst_read_master: issues one AXI4 INCR read burst per command and streams the returned beats out.
module axi_burst_read_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int BYTES_PER_WORD = DATA_WIDTH / 8
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [7:0]               cmd_len,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    axi_burst_read_master_if.master  axi,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     done,
    output logic                     err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]               state;
    logic [8:0]               beat_cnt;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [7:0]               len_q;
    logic                     in_data;
    logic                     beat;
    logic                     cnt_hit;

    assign in_data      = aresetn && state == DATA;
    assign cnt_hit      = beat_cnt == {1'b0, len_q};
    assign beat         = in_data && axi.rvalid && out_ready;
    assign cmd_ready    = aresetn && state == IDLE;
    assign axi.araddr   = addr_q;
    assign axi.arlen    = len_q;
    assign axi.arsize   = 3'($clog2(BYTES_PER_WORD));
    assign axi.arburst  = 2'b01;
    assign axi.arvalid  = state == ADDR;
    assign axi.rready   = in_data && out_ready;
    assign out_valid    = in_data && axi.rvalid;
    assign out_data     = axi.rdata;
    assign out_last     = in_data && (cnt_hit || axi.rlast);
    assign done         = state == DONE;

    // The burst ends on whichever comes first: the counted last beat or rlast; any disagreement is an error.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state    <= IDLE;
            beat_cnt <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    addr_q <= cmd_addr;
                    len_q  <= cmd_len;
                    err    <= 1'b0;
                    state  <= ADDR;
                end
                ADDR: if (axi.arready) begin
                    beat_cnt <= '0;
                    state    <= DATA;
                end
                DATA: if (beat) begin
                    beat_cnt <= beat_cnt + 9'd1;
                    if (axi.rresp != 2'b00 || axi.rlast != cnt_hit) err <= 1'b1;
                    if (cnt_hit || axi.rlast) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/axi_burst_read_master.md
Name: axi_burst_read_master

Overview:
- AXI4 read-only master that turns a single-beat command (base address, beat count) into one INCR read burst on the AR/R channels.
- Forwards returned beats to a downstream valid/ready stream.
- Sits directly upstream of the team's AXI slave RAM and drives its read address channel and read data channel.
- Reports burst completion and error status for test harnesses and DMA-style sequencers.

Parameters:
- DATA_WIDTH, 32, width of rdata and out_data in bits; power of two, 8..1024.
- ADDRESS_WIDTH, 8, width of cmd_addr and araddr in bits.
- BYTES_PER_WORD, DATA_WIDTH/8, bytes per beat; arsize = log2(BYTES_PER_WORD).

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- aresetn  in  1  synchronous active-low reset.
- cmd_addr  in  ADDRESS_WIDTH  burst start byte address.
- cmd_len  in  8  beats minus one (AXI arlen encoding).
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- araddr  out  ADDRESS_WIDTH  AXI read address.
- arlen  out  8  AXI burst length.
- arsize  out  3  AXI beat size, constant log2(BYTES_PER_WORD).
- arburst  out  2  AXI burst type, constant 2'b01 (INCR).
- arvalid  out  1  AXI address valid.
- arready  in  1  AXI address ready.
- rdata  in  DATA_WIDTH  AXI read data.
- rresp  in  2  AXI read response.
- rlast  in  1  AXI last beat.
- rvalid  in  1  AXI read valid.
- rready  out  1  AXI read ready.
- out_data  out  DATA_WIDTH  stream data.
- out_last  out  1  final beat of the burst.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- done  out  1  one-cycle pulse when the burst completes.
- err  out  1  sticky burst error; valid from done until the next command is accepted.

Behaviour:
- Clock aclk; reset aresetn is synchronous and active-low.
- Reset:
  - state=IDLE, beat_cnt=0, arvalid=0, done=0, err=0, latched addr/len=0.
  - While aresetn=0, cmd_ready, rready and out_valid are forced to 0.
- States: IDLE, ADDR, DATA, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch cmd_addr and cmd_len, clear err, go to ADDR.
  - Latency from command acceptance to arvalid=1 is 1 cycle.
- ADDR:
  - arvalid=1; araddr/arlen come from the latched values and stay stable until the handshake.
  - arvalid never drops without arready.
  - On arready: go to DATA and clear beat_cnt to 0.
  - rready=0 in this state.
- DATA (pass-through, zero-latency combinational path):
  - out_valid=rvalid, out_data=rdata, rready=out_ready.
  - out_last=(beat_cnt==latched len) || rlast.
- Beat accepted (rvalid&&rready):
  - beat_cnt increments (9-bit counter, no wrap for len ≤ 255).
  - err is set if rresp!=2'b00.
  - err is set if rlast!=(beat_cnt==len).
- Burst termination:
  - The burst ends on the accepted beat where beat_cnt==len OR rlast=1, whichever comes first; then go to DONE.
  - Early rlast ends the burst and sets err.
  - Missing rlast on the final counted beat ends the burst and sets err.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - cmd_ready=0 in DONE; the earliest next command acceptance is the cycle after done.
- Back-to-back commands are supported.
  - Minimum per-burst overhead with arready and rvalid held high: 1 (ADDR) + len+1 (DATA) + 1 (DONE) cycles after acceptance.
- Outside DATA: rready=0, out_valid=0.
- Backpressure: out_ready=0 holds rready=0; rdata is not buffered.
- Address alignment is not checked; araddr is driven exactly as given. No 4 KB-boundary split (ADDRESS_WIDTH ≤ 12 by use).
- Reset mid-burst:
  - Returns to IDLE next cycle and drops arvalid/rready.
  - Outstanding slave beats are the bench's responsibility; the slave is reset by the same aresetn.
- rvalid outside DATA is ignored (rready=0).

Test Plan:
- Single beat: cmd_addr=0x10, cmd_len=0, arready=1, rdata=0xDEADBEEF with rlast=1 → araddr=0x10, arlen=0, arsize=2, arburst=1; one out beat with out_last=1; done pulse; err=0.
- Four-beat burst: cmd_len=3, rdata 1,2,3,4 with rlast on beat 4 → out_data 1,2,3,4 in order; out_last only on beat 4; done 1 cycle after beat 4; err=0.
- Backpressure: cmd_len=3, out_ready toggles 1,0,0,1,… → rready mirrors out_ready; no beat lost or duplicated; beat_cnt advances only on handshakes.
- AR stall: arready low for 5 cycles → arvalid stays 1 and araddr/arlen stay constant for all 6 cycles; rready=0 throughout.
- Errors: cmd_len=3 with rresp=2'b10 on beat 2 → err=1 at done. Separately, cmd_len=3 with rlast on beat 2 → burst ends after 2 beats with out_last=1 on beat 2 and err=1.
- Reset mid-burst: aresetn=0 during beat 2 of 4 → next cycle state IDLE and arvalid=rready=out_valid=done=0; after release, a new cmd_len=0 burst completes with err=0.
